dec_scan: RTL and testbench
===========================

DEC_SCAN -- requirements
Module: dec_scan

Interface
REQ-001 Parameter N, default 3, SHALL set the select width; the decoder SHALL have 2**N outputs (N from 1 to 6).
REQ-002 Parameter DWELL_W, default 4, SHALL set the width of the dwell count.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 a  input  N  SHALL be the select index, or the start index for a scan.
REQ-006 load  input  1  SHALL be a one-cycle request to latch a and hold its decode.
REQ-007 scan_start  input  1  SHALL be a one-cycle request to begin a walking-one scan from index a.
REQ-008 dwell  input  DWELL_W  SHALL give the number of cycles per scan step minus one, sampled at each step start.
REQ-009 clr  input  1  SHALL be a synchronous abort that returns the block to IDLE.
REQ-010 en  input  1  SHALL be the output enable; it has no effect on state.
REQ-011 y  output  2**N  SHALL be the one-hot decoded output, or all zeros.
REQ-012 busy  output  1  SHALL be high while in SCAN.
REQ-013 done  output  1  SHALL be a one-cycle pulse when a scan completes.

Function
REQ-014 The block SHALL have three states: IDLE, HOLD and SCAN.
REQ-015 Request priority SHALL be, from highest: clr, scan_start, load.
REQ-016 IDLE: y_reg SHALL be zero; load SHALL go to HOLD with idx=a; scan_start SHALL go to SCAN with idx=a and cnt=dwell.
REQ-017 HOLD: y_reg SHALL be onehot(idx); load SHALL update idx=a; scan_start SHALL go to SCAN as in IDLE; clr SHALL go to IDLE.
REQ-018 SCAN: y_reg SHALL be onehot(idx), and each idx SHALL be held for dwell+1 cycles (cnt decrements to 0).
REQ-019 SCAN at cnt==0 and idx<2**N-1: idx SHALL increment and cnt SHALL reload from the current dwell.
REQ-020 SCAN at cnt==0 and idx==2**N-1: the block SHALL go to IDLE, done SHALL be 1 for exactly one cycle (the first IDLE cycle), and y_reg SHALL be 0 in that cycle; idx SHALL never wrap.
REQ-021 In SCAN, load and scan_start SHALL be ignored (no restart); clr SHALL abort to IDLE with no done pulse.
REQ-022 Latency: y_reg SHALL reflect a request on the edge that samples it (one cycle from request to output).
REQ-023 y SHALL equal y_reg when en=1, and all zeros when en=0, combinationally; busy and done SHALL NOT be gated by en.
REQ-024 y_reg SHALL have at most one bit set in every cycle.
REQ-025 dwell=0 SHALL give one cycle per index; dwell=2**DWELL_W-1 SHALL give 2**DWELL_W cycles per index, with no overflow.
REQ-026 scan_start with a=2**N-1 SHALL produce a single step followed by done.

Reset
REQ-027 When rst_n=0, the block SHALL asynchronously enter IDLE with idx=0, cnt=0, y_reg=0, busy=0 and done=0.
REQ-028 Reset asserted mid-scan SHALL abandon the scan with no done pulse.
REQ-029 After rst_n deasserts, the block SHALL act on requests from the first rising clk edge.

Structure
REQ-030 Package dec_scan_pkg SHALL hold the state enum (IDLE, HOLD, SCAN) as typedef state_t.
REQ-031 The block SHALL instantiate one sub-module, dec_n, a parametrised combinational N-to-2**N decoder (with enable) that computes onehot(idx).
REQ-032 The FSM, idx register and cnt register SHALL live in dec_scan.

Verification (N=3, DWELL_W=4)
REQ-033 Reset, then load with a=5 and en=1 -> next cycle y=8'b0010_0000, busy=0.
REQ-034 scan_start with a=6, dwell=1 -> y=0x40 for 2 cycles, then 0x80 for 2 cycles; next cycle y=0 and done=1 for one cycle.
REQ-035 clr and scan_start in the same cycle from HOLD -> IDLE, y=0, no done pulse.
REQ-036 Mid-scan load with a=2 -> ignored, scan continues; then en=0 for 3 cycles -> y=0 while busy stays 1 and the step timing is unchanged.
REQ-037 rst_n pulsed low mid-scan between clock edges -> y=0 and busy=0 immediately, and no done pulse follows.
REQ-038 An assertion SHALL check that y_reg is one-hot or zero, and that done is never high for two consecutive cycles.

Source files
------------

// File: rtl/dec_scan_pkg.sv
// rtl/dec_scan_pkg.sv - shared types for the decoder/scanner block
package dec_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

endpackage

// File: rtl/dec_n.sv
// rtl/dec_n.sv - combinational N-to-2**N one-hot decoder with enable
module dec_n #(
  parameter int N = 3
) (
  input  logic [N-1:0]    sel,
  input  logic            en,
  output logic [2**N-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/dec_scan.sv
// rtl/dec_scan.sv - latched decoder with a walking-one scan mode
module dec_scan
  import dec_scan_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       a,
  input  logic               load,
  input  logic               scan_start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               clr,
  input  logic               en,
  output logic [2**N-1:0]    y,
  output logic               busy,
  output logic               done
);

  localparam logic [N-1:0] IDX_MAX = {N{1'b1}};

  state_t             state, state_n;
  logic [N-1:0]       idx, idx_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic               done_n;
  logic [2**N-1:0]    y_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  end

  // clr outranks everything; load and scan_start are deaf while scanning
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    done_n  = 1'b0;
    if (clr) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          if (scan_start) begin
            state_n = SCAN;
            idx_n   = a;
            cnt_n   = dwell;
          end else if (load) begin
            state_n = HOLD;
            idx_n   = a;
          end
        end
        SCAN: begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else if (idx != IDX_MAX) begin
            idx_n = idx + 1'b1;
            cnt_n = dwell;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  dec_n #(.N(N)) u_dec (
    .sel (idx),
    .en  (state != IDLE),
    .y   (y_reg)
  );

  assign y    = en ? y_reg : '0;
  assign busy = (state == SCAN);

  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(y_reg));
  a_done_1c : assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

endmodule

// File: tb/tb_dec_scan.sv
// tb/tb_dec_scan.sv - randomized self-checking bench for dec_scan
module tb_dec_scan;

  localparam int N   = 3;
  localparam int DW  = 4;
  localparam int MAX = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  a;
  logic          load;
  logic          scan_start;
  logic [DW-1:0] dwell;
  logic          clr;
  logic          en;
  logic [7:0]    y;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  dec_scan #(.N(N), .DWELL_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .load       (load),
    .scan_start (scan_start),
    .dwell      (dwell),
    .clr        (clr),
    .en         (en),
    .y          (y),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  // Reference: a scan from a0 visits a0..MAX, each for d+1 cycles; k counts cycles after the start edge
  function automatic int scan_len(int a0, int d);
    return (MAX - a0 + 1) * (d + 1);
  endfunction

  function automatic logic [7:0] scan_y(int a0, int d, int k);
    int pos;
    pos = a0 + k / (d + 1);
    if (k >= scan_len(a0, d)) return 8'h00;
    return 8'(1) << pos;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a = '0; load = 0; scan_start = 0; dwell = '0; clr = 0; en = 1;
    #12;
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h want 00", y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL idle_y: got %h want 00", y); end
  endtask

  task automatic test_load();
    logic [N-1:0] r;
    a = 3'd5; load = 1; en = 1;
    cycle();
    load = 0;
    checks++; if (y !== 8'b0010_0000) begin errors++; $display("FAIL load5_y: got %h want 20", y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load5_busy: got %b want 0", busy); end
    en = 0;
    #1;
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL load_en0_y: got %h want 00", y); end
    en = 1;
    for (int i = 0; i < 8; i++) begin
      r = 3'($urandom_range(0, 7));
      a = r; load = 1;
      cycle();
      load = 0; a = 3'($urandom_range(0, 7));
      checks++; if (y !== (8'(1) << r)) begin errors++; $display("FAIL load_rand_y: got %h want %h", y, 8'(1) << r); end
      cycle();
      checks++; if (y !== (8'(1) << r)) begin errors++; $display("FAIL hold_rand_y: got %h want %h", y, 8'(1) << r); end
    end
  endtask

  task automatic test_scan_basic();
    logic [7:0] ey[6];
    logic       ed[6];
    logic       eb[6];
    ey = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h00, 8'h00};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    a = 3'd6; dwell = 4'd1; scan_start = 1; en = 1;
    cycle();
    scan_start = 0;
    for (int k = 0; k < 6; k++) begin
      checks++; if (y !== ey[k]) begin errors++; $display("FAIL basic_y[%0d]: got %h want %h", k, y, ey[k]); end
      checks++; if (done !== ed[k]) begin errors++; $display("FAIL basic_done[%0d]: got %b want %b", k, done, ed[k]); end
      checks++; if (busy !== eb[k]) begin errors++; $display("FAIL basic_busy[%0d]: got %b want %b", k, busy, eb[k]); end
      cycle();
    end
  endtask

  // Back-to-back scans: each new scan_start is issued in the previous scan's done cycle
  task automatic test_scan_random();
    int a0, d, len;
    logic [7:0] ey;
    for (int it = 0; it < 8; it++) begin
      case (it)
        0: begin a0 = 0; d = 0; end
        1: begin a0 = 7; d = 0; end
        2: begin a0 = 7; d = 15; end
        3: begin a0 = 5; d = 15; end
        default: begin a0 = $urandom_range(0, 7); d = $urandom_range(0, 5); end
      endcase
      len = scan_len(a0, d);
      a = 3'(a0); dwell = 4'(d); scan_start = 1; load = $urandom_range(0, 1);
      cycle();
      for (int k = 0; k <= len; k++) begin
        ey = en ? scan_y(a0, d, k) : 8'h00;
        checks++; if (y !== ey) begin errors++; $display("FAIL rand_y it%0d k%0d: got %h want %h", it, k, y, ey); end
        checks++; if (busy !== (k < len)) begin errors++; $display("FAIL rand_busy it%0d k%0d: got %b want %b", it, k, busy, k < len); end
        checks++; if (done !== (k == len)) begin errors++; $display("FAIL rand_done it%0d k%0d: got %b want %b", it, k, done, k == len); end
        if (k < len) begin
          en = ($urandom_range(0, 3) != 0);
          load = ($urandom_range(0, 2) == 0);
          scan_start = ($urandom_range(0, 4) == 0);
          a = 3'($urandom_range(0, 7));
          cycle();
        end else begin
          load = 0; scan_start = 0; en = 1;
        end
      end
    end
    cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rand_done_after: got %b want 0", done); end
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL rand_y_after: got %h want 00", y); end
  endtask

  task automatic test_clr();
    a = 3'd3; load = 1; en = 1;
    cycle();
    load = 0;
    clr = 1; scan_start = 1; a = 3'd1; dwell = 4'd0;
    cycle();
    clr = 0; scan_start = 0;
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL clr_hold_y: got %h want 00", y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_hold_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_hold_done: got %b want 0", done); end
    a = 3'd0; dwell = 4'd1; scan_start = 1;
    cycle();
    scan_start = 0;
    repeat (3) cycle();
    clr = 1;
    cycle();
    clr = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_scan_busy: got %b want 0", busy); end
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL clr_scan_y: got %h want 00", y); end
    for (int k = 0; k < 20; k++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_scan_done k%0d: got %b want 0", k, done); end
      cycle();
    end
  endtask

  task automatic test_mid_scan_load_en();
    int len;
    logic [7:0] ey;
    len = scan_len(4, 2);
    a = 3'd4; dwell = 4'd2; scan_start = 1; en = 1;
    cycle();
    scan_start = 0;
    for (int k = 0; k <= len; k++) begin
      ey = en ? scan_y(4, 2, k) : 8'h00;
      checks++; if (y !== ey) begin errors++; $display("FAIL mid_y k%0d: got %h want %h", k, y, ey); end
      checks++; if (busy !== (k < len)) begin errors++; $display("FAIL mid_busy k%0d: got %b want %b", k, busy, k < len); end
      checks++; if (done !== (k == len)) begin errors++; $display("FAIL mid_done k%0d: got %b want %b", k, done, k == len); end
      load = (k == 0);
      a = (k == 0) ? 3'd2 : 3'd4;
      en = !(k >= 2 && k <= 4);
      cycle();
    end
    load = 0; en = 1;
  endtask

  task automatic test_reset_mid_scan();
    a = 3'd1; dwell = 4'd3; scan_start = 1; en = 1;
    cycle();
    scan_start = 0;
    repeat (3) cycle();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL rstmid_y: got %h want 00", y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    #1;
    a = 3'd3; load = 1;
    rst_n = 1'b1;
    cycle();
    load = 0;
    checks++; if (y !== 8'h08) begin errors++; $display("FAIL rst_first_edge_y: got %h want 08", y); end
    for (int k = 0; k < 20; k++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done k%0d: got %b want 0", k, done); end
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_scan_basic();
    test_scan_random();
    test_clr();
    test_mid_scan_load_en();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
